mux_bus_arbiter: RTL and testbench
==================================

Name: mux_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit result bus, built from mux8x1, among 8 requesters.
- Drives the 3-bit mux select and a one-hot grant vector.
- Caps bus tenure at MAX_BURST cycles while other requesters wait.
- Sits between the requesting units and the mux8x1 instance; contains no datapath logic itself.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the mux8x1 select width. Other values are unsupported.
- MAX_BURST, 4, maximum consecutive granted cycles while another requester is pending. Legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i wants the bus.
- grant  output  8  one-hot grant, registered; all zeros when idle.
- sel  output  3  binary index of the granted requester; drives mux8x1 sel.
- bus_valid  output  1  high when grant is non-zero, so the mux output is meaningful.
- burst_cnt  output  4  cycles of current tenure minus one; for debug and verification.

Behaviour:
- Reset values: grant=0, sel=0, bus_valid=0, burst_cnt=0, priority pointer ptr=0, state=IDLE.
- State machine: IDLE and OWNED.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise pick winner w = the first set bit of req, searching circularly from ptr upward (7 wraps to 0).
  - Next cycle: state=OWNED, grant=1<<w, sel=w, bus_valid=1, burst_cnt=0.
  - Latency from req to grant is exactly 1 cycle.
- OWNED, owner o. Evaluate in the current cycle; let others = req with bit o masked off.
  - (a) req[o]=0 (owner releases): set ptr=(o+1) mod 8.
    - If others is non-zero, arbitrate among others from the new ptr. The new grant appears next cycle with no idle bubble, burst_cnt=0.
    - Otherwise go to IDLE next cycle with grant=0, bus_valid=0, and sel holding its last value.
  - (b) req[o]=1, burst_cnt==MAX_BURST-1, and others non-zero: forced rotation. Same as (a) with others non-zero; the owner is preempted.
  - (c) req[o]=1, burst_cnt==MAX_BURST-1, and others zero: keep the owner and wrap burst_cnt to 0. A lone requester may hold the bus indefinitely.
  - (d) Otherwise keep the owner and increment burst_cnt.
- MAX_BURST=1: under contention, ownership rotates every cycle.
- ptr updates only when ownership ends, to (owner+1) mod 8. Wrap-around: owner 7 gives ptr=0.
- Invariants:
  - grant is always zero or one-hot.
  - sel equals the index of the set grant bit whenever bus_valid=1.
  - bus_valid == |grant.
- Requests are level-sensitive. A requester that drops req before being granted is simply not selected; no request is latched.
- Reset mid-tenure: the next cycle shows reset values regardless of req, and arbitration restarts from ptr=0.
- All outputs are registered; there is no combinational path from req to grant or sel.

Decomposition:
- Shared package holds:
  - N_REQ=8 and SEL_W=3 constants.
  - The state encoding: IDLE=1'b0, OWNED=1'b1.
  - A function converting one-hot to index.
- One natural sub-module: rr_priority_pick. It is combinational; it takes an 8-bit request vector and a 3-bit ptr and returns a one-hot winner, its index, and an any flag.
  - Implement it as a rotate, then a fixed-priority find-first, then a rotate back.
  - The main block instantiates it once; its input is req in IDLE and others in OWNED.
- The top-level integration instantiates mux8x1 separately; it is not part of this block.

Test Plan:
- Reset and single request:
  - Assert reset 2 cycles with req=8'hFF → grant=0, sel=0, bus_valid=0.
  - Release reset, req=8'h04 → one cycle later grant=8'h04, sel=2, bus_valid=1; held while req stays set.
- Simultaneous requests, round-robin: ptr=0, req=8'h81 held, MAX_BURST=4 → grant 8'h01 for 4 cycles, then 8'h80 for 4, then 8'h01; each handover happens with no zero-grant cycle.
- Voluntary release without bubble: owner 3 drops req while req[5]=1 → the next cycle shows grant=8'h20, sel=5, burst_cnt=0.
- Release to idle and wrap-around:
  - Owner 7 drops with req=0 → grant=0 and bus_valid=0 next cycle.
  - Then req=8'h81 → grant=8'h01, because ptr wrapped to 0.
- Lone requester beyond cap: req=8'h10 held 10 cycles with MAX_BURST=4 → grant stays 8'h10; burst_cnt counts 0,1,2,3,0,1,...
- Reset mid-tenure: during owner 6 at burst_cnt=2, pulse reset 1 cycle with req=8'h41 → outputs clear; the next grant is 8'h01 (ptr=0).

Source files
------------

// File: rtl/mux_bus_arbiter_pkg.sv
// Shared definitions for the mux_bus_arbiter block.
// Holds the requester count and select width, the FSM state encoding,
// and a one-hot to binary index helper.
package mux_bus_arbiter_pkg;

  localparam int unsigned N_REQ   = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned BURST_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Assumes the input is zero or one-hot; zero maps to index 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx |= SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_bus_arbiter_if.sv
// Bus between the requesting units and the arbiter.
//   req       : request vector, one bit per requester
//   grant     : registered one-hot grant, zero when idle
//   sel       : index of the granted requester (drives mux8x1 sel)
//   bus_valid : high while any grant is active
//   burst_cnt : cycles of current tenure minus one (debug)
// master modport: arbiter side. slave modport: requester side.
interface mux_bus_arbiter_if;
  import mux_bus_arbiter_pkg::*;

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   grant;
  logic [SEL_W-1:0]   sel;
  logic               bus_valid;
  logic [BURST_W-1:0] burst_cnt;

  modport master (input req, output grant, output sel, output bus_valid, output burst_cnt);
  modport slave  (output req, input grant, input sel, input bus_valid, input burst_cnt);
endinterface

// File: rtl/mux_bus_arbiter_pick.sv
// rr_priority_pick: combinational round-robin winner selection.
//   req    : candidate request vector
//   ptr    : index with highest priority; search proceeds upward, wrapping
//   winner : one-hot winner (zero if req is zero)
//   idx    : binary index of the winner
//   any    : high if any request is present
module rr_priority_pick
  import mux_bus_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] first;

  always_comb begin
    // Rotate so that bit ptr lands at position 0.
    rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i + ptr)];
    end

    // Fixed priority: isolate the lowest set bit.
    first = rot & (~rot + 1'b1);

    // Rotate back into requester numbering.
    winner = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      winner[SEL_W'(i + ptr)] = first[i];
    end

    idx = onehot_to_idx(first) + ptr;
    any = |req;
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: round-robin arbiter for one shared 32-bit result bus.
// Produces a registered one-hot grant and mux select for 8 requesters and
// caps tenure at MAX_BURST cycles while another requester is waiting.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : master modport of mux_bus_arbiter_if (req in; grant, sel,
//           bus_valid, burst_cnt out)
module mux_bus_arbiter
  import mux_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux_bus_arbiter_if.master  bus
);

  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic [N_REQ-1:0]   others;
  logic [N_REQ-1:0]   pick_req;
  logic [N_REQ-1:0]   pick_onehot;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               at_cap;
  logic               handover;

  // In OWNED the picker already sees the post-release pointer (owner+1),
  // so handover and ptr update share one arbitration result.
  always_comb begin
    others    = bus.req & ~grant_q;
    owner_req = |(bus.req & grant_q);
    at_cap    = (burst_q == BURST_CAP);
    pick_req  = (state_q == IDLE) ? bus.req : others;
    pick_ptr  = (state_q == IDLE) ? ptr_q : sel_q + 1'b1;
    handover  = !owner_req || (at_cap && pick_any);
  end

  rr_priority_pick u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = OWNED;
      OWNED:   if (handover && !pick_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output logic
  always_comb begin
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        if (pick_any) begin
          grant_d = pick_onehot;
          sel_d   = pick_idx;
        end else begin
          grant_d = '0;
        end
      end
      OWNED: begin
        if (handover) begin
          ptr_d   = pick_ptr;
          burst_d = '0;
          if (pick_any) begin
            grant_d = pick_onehot;
            sel_d   = pick_idx;
          end else begin
            grant_d = '0;
          end
        end else begin
          // Lone owner at the cap wraps the counter and keeps the bus.
          burst_d = at_cap ? '0 : burst_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        burst_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.grant     = grant_q;
    bus.sel       = sel_q;
    bus.bus_valid = |grant_q;
    bus.burst_cnt = burst_q;
  end

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));
  a_sel_matches:   assert property (@(posedge clk) (|grant_q) |-> (sel_q == onehot_to_idx(grant_q)));

endmodule

// File: tb/tb_mux_bus_arbiter.sv
module tb_mux_bus_arbiter;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic [3:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  mux_bus_arbiter_if bus0();
  mux_bus_arbiter_if bus1();

  mux_bus_arbiter #(.MAX_BURST(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mux_bus_arbiter #(.MAX_BURST(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e, input logic [7:0] g, input logic [2:0] s,
                       input logic v, input logic [3:0] b);
    total++;
    if (g !== e.g || s !== e.s || v !== e.v || b !== e.b) begin
      bad++;
      $display("FAIL %s cyc=%0d got grant=%h sel=%0d valid=%0b burst=%0d want grant=%h sel=%0d valid=%0b burst=%0d",
               e.tag, cyc, g, s, v, b, e.g, e.s, e.v, e.b);
    end
  endtask

  // Monitor: compares each queued expectation in the cycle it targets.
  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc <= cyc) begin
      check(q0.pop_front(), bus0.grant, bus0.sel, bus0.bus_valid, bus0.burst_cnt);
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      check(q1.pop_front(), bus1.grant, bus1.sel, bus1.bus_valid, bus1.burst_cnt);
    end
  end

  // Apply inputs for the next edge and queue the outputs expected after it.
  task automatic drv(input string tag, input logic rst, input logic [7:0] r,
                     input logic [7:0] g, input logic [2:0] s, input logic v, input logic [3:0] b);
    exp_t e;
    reset = rst;
    bus0.req = r;
    e.cyc = cyc + 1; e.tag = tag; e.g = g; e.s = s; e.v = v; e.b = b;
    q0.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drv1(input string tag, input logic [7:0] r,
                      input logic [7:0] g, input logic [2:0] s, input logic v, input logic [3:0] b);
    exp_t e;
    reset = 1'b0;
    bus1.req = r;
    e.cyc = cyc + 1; e.tag = tag; e.g = g; e.s = s; e.v = v; e.b = b;
    q1.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus1.req = 8'h00;
    // Reset with every request asserted
    drv("reset0", 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 4'd0);
    drv("reset1", 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 4'd0);
    // Single request: one cycle latency, lone holder wraps burst_cnt
    drv("single0", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 4'd0);
    drv("single1", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 4'd1);
    drv("single2", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 4'd2);
    drv("single3", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 4'd3);
    drv("single4", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 4'd0);
    drv("idle_hold_sel", 1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 4'd0);
    // Fresh ptr=0, contention between 0 and 7
    drv("rr_reset", 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 4'd0);
    drv("rr0", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 4'd0);
    drv("rr1", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 4'd1);
    drv("rr2", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 4'd2);
    drv("rr3", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 4'd3);
    drv("rr4", 1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 4'd0);
    drv("rr5", 1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 4'd1);
    drv("rr6", 1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 4'd2);
    drv("rr7", 1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 4'd3);
    drv("rr8", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 4'd0);
    // Voluntary release without bubble: 0 -> 3 -> 5
    drv("rel_to3", 1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 4'd0);
    drv("own3", 1'b0, 8'h28, 8'h08, 3'd3, 1'b1, 4'd1);
    drv("rel_to5", 1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 4'd0);
    // Owner 7 releases to idle; ptr wraps to 0
    drv("to7", 1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 4'd0);
    drv("idle7", 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, 4'd0);
    drv("wrap0", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 4'd0);
    // Lone requester beyond the cap
    for (int i = 0; i < 10; i++) begin
      drv("lone", 1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 4'(i % 4));
    end
    // Reset mid-tenure of owner 6 at burst_cnt=2
    drv("own6_0", 1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 4'd0);
    drv("own6_1", 1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 4'd1);
    drv("own6_2", 1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 4'd2);
    drv("mid_reset", 1'b1, 8'h41, 8'h00, 3'd0, 1'b0, 4'd0);
    drv("post_reset", 1'b0, 8'h41, 8'h01, 3'd0, 1'b1, 4'd0);
    drv("post_reset1", 1'b0, 8'h41, 8'h01, 3'd0, 1'b1, 4'd1);
    drv("final_idle", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 4'd0);
    // MAX_BURST=1: rotation every cycle under contention
    drv1("mb1_0", 8'h03, 8'h01, 3'd0, 1'b1, 4'd0);
    drv1("mb1_1", 8'h03, 8'h02, 3'd1, 1'b1, 4'd0);
    drv1("mb1_2", 8'h03, 8'h01, 3'd0, 1'b1, 4'd0);
    drv1("mb1_lone", 8'h01, 8'h01, 3'd0, 1'b1, 4'd0);
    drv1("mb1_idle", 8'h00, 8'h00, 3'd0, 1'b0, 4'd0);

    for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++) @(posedge clk);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
